mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised successor to the single-cycle CPU memory hookup. Today fetch and data each have a private, zero-wait memory.
- This block lets NUM_PORTS requesters share one unified memory that may insert wait states. By convention port 0 is instruction fetch and ports 1..N-1 are data/load-store.
- It arbitrates, launches one memory transaction at a time through a req/ready handshake, and returns a one-cycle ack (optionally with error) to the winner.
- It sits between the datapath/controller and a single memory model inside the CPU top level.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- MAX_WAIT, 15, cycles in ISSUE before timeout; 0 disables timeout

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstIn  in  1  reset, asynchronous, active-low
- req  in  NUM_PORTS  per-port request, held until ack
- we  in  NUM_PORTS  per-port write enable (1 = store)
- addr  in  NUM_PORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  packed write data
- ack  out  NUM_PORTS  one-cycle completion pulse to the winner
- err  out  NUM_PORTS  one-cycle timeout flag, coincident with ack
- rdata  out  DATA_W  read data, valid in the ack cycle
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid when m_ready=1
- m_ready  in  1  memory completes the transaction this cycle

Behaviour:
- Reset (rstIn=0, asynchronous):
  - state=IDLE; ack, err, m_req, m_we = 0; m_addr, m_wdata, rdata = 0; rr pointer = 0; wait counter = 0.
  - Applies immediately mid-transaction: m_req drops without waiting for m_ready, and the in-flight request is lost (no ack).
- FSM states IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, select winner w, register w plus addr/we/wdata of w into m_addr/m_we/m_wdata, clear wait counter, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - m_req=1; m_addr/m_we/m_wdata stay stable for the whole state.
  - On m_ready=1: go to RESP; if m_we=0, rdata<=m_rdata.
  - Else if MAX_WAIT!=0 and counter==MAX_WAIT-1: go to RESP with error set and rdata<=0.
  - Otherwise counter increments.
- RESP:
  - ack[w]=1 (and err[w]=1 if timed out) for exactly this one cycle; m_req=0.
  - req is ignored in this cycle; go to IDLE.
  - In round-robin mode the pointer becomes (w+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
- Latency: req seen at edge k -> m_req high in cycle k+1 -> with m_ready in that same cycle, ack in cycle k+2. Minimum 3 cycles per transaction; throughput is one transaction per 3 cycles plus wait states.
- Arbitration:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: first set index at or after the pointer, wrapping.
  - Only one winner, even when all ports request simultaneously.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req in the ack cycle, or it is re-granted on the next IDLE cycle.
  - Changing a non-granted port's inputs is allowed at any time.
- Writes leave rdata unchanged. rdata holds its value between acks.
- m_ready outside ISSUE is ignored.
- Timeout completion returns rdata=0. For a write, memory state is undefined, and the requester must treat err as a fault.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - PRIO_FIXED/PRIO_RR constants;
  - default ADDR_W/DATA_W of 16, matching the CPU word.
- One natural sub-module: rr_arbiter (combinational winner select from req plus pointer, both modes).
- The FSM, latches and timeout counter stay in mem_port_arbiter.

Test Plan:
- Single read, zero wait: port0 req, addr=16'h0004; memory returns 16'hBEEF with m_ready in the first ISSUE cycle -> m_req high exactly 1 cycle, ack=2'b01 two cycles after req is sampled, rdata=16'hBEEF, err=0.
- Write with 3 wait states: port1 we=1, addr=16'h0010, wdata=16'h1234; m_ready asserted on the 4th ISSUE cycle -> m_addr/m_wdata stable for 4 cycles, ack=2'b10, rdata unchanged from the prior value.
- Contention, fixed priority: both ports request continuously, dropping req only in their own ack cycle -> port0 is granted first; port1 is granted only after port0 deasserts.
- Contention, round-robin, NUM_PORTS=4: all four ports request continuously -> grant order 0,1,2,3,0 (wraps), one ack per transaction, never two ack bits high together.
- Timeout: MAX_WAIT=15, m_ready never asserted -> after 15 ISSUE cycles, ack and err pulse together for the winner, rdata=0, FSM returns to IDLE.
- Reset mid-op: assert rstIn=0 during ISSUE between clock edges -> m_req, ack and err go to 0 immediately; after release, a new request completes normally and the round-robin pointer restarts at 0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory port arbiter: FSM encoding,
// arbitration mode selectors and the default CPU word geometry.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select. Fixed mode: lowest set index wins.
// Round-robin mode: first set index at or after ptr, wrapping.
module rr_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PRIO_MODE = PRIO_FIXED,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic                 gnt_vld,
  output logic [PW-1:0]        gnt_idx
);

  // scan from the start index, wrapping once; first hit wins
  always_comb begin
    int base;
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    base    = (PRIO_MODE == PRIO_RR) ? int'(ptr) : 0;
    j       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = base + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one wait-state memory among NUM_PORTS requesters. One transaction
// in flight at a time: IDLE picks a winner and latches its request, ISSUE
// holds m_req until m_ready (or timeout), RESP pulses ack/err to the winner.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int DATA_W    = CPU_DATA_W,
  parameter int PRIO_MODE = PRIO_FIXED,
  parameter int MAX_WAIT  = 15
) (
  input  logic                          clk,
  input  logic                          rstIn,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [NUM_PORTS-1:0]          err,
  output logic [DATA_W-1:0]             rdata,
  output logic                          m_req,
  output logic                          m_we,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic                          m_ready
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  // counter only needs to reach MAX_WAIT-1
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  state_t          state, state_nx;
  logic [PW-1:0]   wsel;      // latched winner
  logic [PW-1:0]   ptr;       // round-robin start index
  logic [PW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic [CW-1:0]   cnt;       // ISSUE cycles elapsed
  logic            tout;      // current transaction ended by timeout
  logic            timeout_hit;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PRIO_MODE (PRIO_MODE),
    .PW        (PW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign timeout_hit = (MAX_WAIT != 0) && (cnt == CNT_LAST);

  // state register; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: ready beats timeout when both land in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld) state_nx = ISSUE;
      ISSUE:   if (m_ready || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state so reset clears them immediately
  always_comb begin
    ack   = '0;
    err   = '0;
    m_req = 1'b0;
    case (state)
      ISSUE: m_req = 1'b1;
      RESP: begin
        ack[wsel] = 1'b1;
        err[wsel] = tout;
      end
      default: ;
    endcase
  end

  // transaction latches, read-data capture, wait counter and rr pointer
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      wsel    <= '0;
      ptr     <= '0;
      cnt     <= '0;
      tout    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          wsel    <= gnt_idx;
          m_we    <= we[gnt_idx];
          m_addr  <= addr[gnt_idx*ADDR_W +: ADDR_W];
          m_wdata <= wdata[gnt_idx*DATA_W +: DATA_W];
          cnt     <= '0;
          tout    <= 1'b0;
        end
        ISSUE: begin
          if (m_ready) begin
            if (!m_we) rdata <= m_rdata;
          end else if (timeout_hit) begin
            tout  <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (PRIO_MODE == PRIO_RR) begin
          ptr <= (wsel == LAST_PORT) ? '0 : wsel + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A 4-port round-robin instance is
// run against a transaction-level model (pending-request table, memory
// array, rotating-priority rule); a 2-port fixed-priority instance gets
// short directed contention and timeout sequences.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 15;

  logic clk;
  logic rstIn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic [N-1:0]    req, we, ack, err;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, m_wdata, m_rdata;
  logic [AW-1:0]   m_addr;
  logic            m_req, m_we, m_ready;

  mem_port_arbiter #(
    .NUM_PORTS (N), .ADDR_W (AW), .DATA_W (DW), .PRIO_MODE (1), .MAX_WAIT (MW)
  ) u_rr (
    .clk (clk), .rstIn (rstIn), .req (req), .we (we), .addr (addr),
    .wdata (wdata), .ack (ack), .err (err), .rdata (rdata), .m_req (m_req),
    .m_we (m_we), .m_addr (m_addr), .m_wdata (m_wdata), .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  // fixed-priority instance
  logic [1:0]  fx_req, fx_we, fx_ack, fx_err;
  logic [31:0] fx_addr, fx_wdata;
  logic [15:0] fx_rdata, fx_m_addr, fx_m_wdata, fx_m_rdata;
  logic        fx_m_req, fx_m_we, fx_m_ready;

  mem_port_arbiter #(
    .NUM_PORTS (2), .ADDR_W (16), .DATA_W (16), .PRIO_MODE (0), .MAX_WAIT (3)
  ) u_fx (
    .clk (clk), .rstIn (rstIn), .req (fx_req), .we (fx_we), .addr (fx_addr),
    .wdata (fx_wdata), .ack (fx_ack), .err (fx_err), .rdata (fx_rdata),
    .m_req (fx_m_req), .m_we (fx_m_we), .m_addr (fx_m_addr),
    .m_wdata (fx_m_wdata), .m_rdata (fx_m_rdata), .m_ready (fx_m_ready)
  );

  // fixed instance memory: read data is a fixed scramble of the address
  assign fx_m_rdata = fx_m_addr ^ 16'hA5A5;

  int errs;
  int checks;

  // model state
  logic [15:0] mem [16];
  bit          pend [N];
  bit          pwe  [N];
  logic [15:0] paddr[N];
  logic [15:0] pdata[N];
  bit          busy, exp_ack, to_exp;
  int          w, n_issue, target, ptr_m, idle_gap, force_tgt, prob;
  logic [15:0] rdata_exp, rd_pend;
  int          gq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // rotating priority: first requester at or after start
  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int p = 0; p < N; p++) if (pend[p]) return 1'b1;
    return 1'b0;
  endfunction

  // requesters: pending ports hold; idle ports may raise or scribble
  task automatic drive_ports(input int skip);
    for (int p = 0; p < N; p++) begin
      if (!pend[p] && p != skip) begin
        pwe[p]   = 1'($urandom_range(1));
        paddr[p] = 16'($urandom);
        pdata[p] = 16'($urandom);
        if (int'($urandom_range(99)) < prob) pend[p] = 1'b1;
      end
      req[p] = pend[p];
      we[p]  = pwe[p];
      addr[p*AW +: AW]  = paddr[p];
      wdata[p*DW +: DW] = pdata[p];
    end
  endtask

  // one clock of observation and stimulus, at the falling edge
  task automatic cyc();
    int skip;
    skip = -1;
    @(negedge clk);
    if (!busy) begin
      chk("ack_idle", ack, 0);
      if (m_req) begin
        w = pick(req, ptr_m);
        if (w < 0) begin chk("grant_without_req", 1, 0); w = 0; end
        chk("m_addr_win", m_addr, paddr[w]);
        chk("m_we_win", m_we, pwe[w]);
        if (pwe[w]) chk("m_wdata_win", m_wdata, pdata[w]);
        busy = 1'b1; n_issue = 1; idle_gap = 0;
        target = (force_tgt >= 0) ? force_tgt :
                 (($urandom_range(7) == 0) ? 100 : int'($urandom_range(4)));
      end else if (req != 0) begin
        idle_gap++;
        if (idle_gap > 1) chk("grant_stall", idle_gap, 1);
      end else begin
        idle_gap = 0;
      end
    end else if (exp_ack) begin
      chk("ack", ack, 1 << w);
      chk("err", err, to_exp ? (1 << w) : 0);
      chk("m_req_resp", m_req, 0);
      if (to_exp) rdata_exp = '0;
      else if (!pwe[w]) rdata_exp = rd_pend;
      gq.push_back(w);
      pend[w] = 1'b0; skip = w;
      ptr_m = (w + 1) % N;
      busy = 1'b0; exp_ack = 1'b0;
    end else begin
      n_issue++;
      chk("m_req_issue", m_req, 1);
      chk("ack_issue", ack, 0);
      chk("m_addr_hold", m_addr, paddr[w]);
      chk("m_we_hold", m_we, pwe[w]);
      if (pwe[w]) chk("m_wdata_hold", m_wdata, pdata[w]);
    end
    chk("rdata", rdata, rdata_exp);
    // memory side for the coming edge; stray m_ready outside ISSUE is noise
    m_rdata = 16'($urandom);
    m_ready = 1'($urandom_range(1));
    if (busy && !exp_ack) begin
      m_ready = 1'b0;
      if (n_issue - 1 == target) begin
        m_ready = 1'b1; exp_ack = 1'b1; to_exp = 1'b0;
        if (pwe[w]) mem[paddr[w][3:0]] = pdata[w];
        else begin m_rdata = mem[paddr[w][3:0]]; rd_pend = m_rdata; end
      end else if (n_issue == MW) begin
        exp_ack = 1'b1; to_exp = 1'b1;
      end
    end
    drive_ports(skip);
  endtask

  task automatic run_acks(input int n);
    int start_n;
    int lim;
    start_n = gq.size();
    lim = 0;
    while (gq.size() < start_n + n && lim < 60 * n) begin cyc(); lim++; end
    if (gq.size() < start_n + n) chk("ack_budget", gq.size(), start_n + n);
  endtask

  task automatic drain();
    int lim;
    lim = 0;
    prob = 0;
    while ((any_pend() || busy) && lim < 200) begin cyc(); lim++; end
    if (any_pend() || busy) chk("drain_budget", 0, 1);
  endtask

  initial begin
    int lim;
    int exp_ord[5];
    int q0, fw, n;
    bit fbusy, done;

    errs = 0; checks = 0;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    busy = 0; exp_ack = 0; to_exp = 0; w = 0; n_issue = 0; target = 0;
    ptr_m = 0; idle_gap = 0; force_tgt = -1; prob = 0;
    rdata_exp = '0; rd_pend = '0;
    m_ready = 1'b0; m_rdata = '0;
    drive_ports(-1);
    fx_req = '0; fx_we = '0; fx_addr = '0; fx_wdata = '0; fx_m_ready = 1'b0;

    rstIn = 1'b1;
    #1 rstIn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_fx_m_req", fx_m_req, 0);
    chk("rst_fx_rdata", fx_rdata, 0);
    rstIn = 1'b1;

    // single read, zero wait
    mem[4] = 16'hBEEF;
    force_tgt = 0;
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 16'h0004;
    drive_ports(-1);
    run_acks(1);
    chk("read_port", gq[gq.size()-1], 0);
    chk("read_beef", rdata, 16'hBEEF);

    // write with three wait states; rdata must not move
    force_tgt = 3;
    pend[1] = 1'b1; pwe[1] = 1'b1; paddr[1] = 16'h0010; pdata[1] = 16'h1234;
    drive_ports(-1);
    run_acks(1);
    chk("write_port", gq[gq.size()-1], 1);
    chk("write_rdata_keep", rdata, 16'hBEEF);

    // reset in the middle of a long ISSUE
    force_tgt = 100;
    pend[2] = 1'b1; pwe[2] = 1'b0; paddr[2] = 16'h0022;
    drive_ports(-1);
    lim = 0;
    while (!(busy && n_issue >= 3) && lim < 20) begin cyc(); lim++; end
    chk("midop_reached", busy && n_issue >= 3, 1);
    #2 rstIn = 1'b0;
    #1;
    chk("midrst_m_req", m_req, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_err", err, 0);
    chk("midrst_rdata", rdata, 0);
    busy = 0; exp_ack = 0; idle_gap = 0; ptr_m = 0; rdata_exp = '0;
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    m_ready = 1'b0;
    drive_ports(-1);
    @(negedge clk);
    rstIn = 1'b1;

    // all four request continuously: pointer restarts at 0
    force_tgt = 0; prob = 100; gq.delete();
    drive_ports(-1);
    run_acks(5);
    exp_ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", gq[i], exp_ord[i]);
    drain();

    // timeout on a lone read
    force_tgt = 100;
    pend[3] = 1'b1; pwe[3] = 1'b0; paddr[3] = 16'h0033;
    drive_ports(-1);
    run_acks(1);
    chk("to_port", gq[gq.size()-1], 3);
    chk("to_rdata", rdata, 0);

    // random traffic
    force_tgt = -1; prob = 35;
    repeat (500) cyc();
    drain();

    // fixed priority: port0 requests three times back to back, then stops
    fx_we = 2'b00; fx_addr = {16'h0200, 16'h0100}; fx_m_ready = 1'b1;
    fx_req = 2'b11; q0 = 3; fbusy = 0; fw = 0;
    gq.delete();
    for (int c = 0; c < 40 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (fbusy) begin
        chk("fx_ack", fx_ack, 1 << fw);
        chk("fx_err", fx_err, 0);
        chk("fx_rdata", fx_rdata, fx_addr[fw*16 +: 16] ^ 16'hA5A5);
        gq.push_back(fw);
        fx_req[fw] = 1'b0;
        if (fw == 0) q0--;
        fbusy = 0;
      end else begin
        chk("fx_ack_idle", fx_ack, 0);
        if (fx_m_req) begin
          if (fx_req == 2'b00) chk("fx_grant_without_req", 1, 0);
          fw = fx_req[0] ? 0 : 1;
          chk("fx_m_addr", fx_m_addr, fx_addr[fw*16 +: 16]);
          fbusy = 1;
        end else if (q0 > 0 && !fx_req[0]) begin
          fx_req[0] = 1'b1;
        end
      end
    end
    chk("fx_grants", gq.size(), 4);
    exp_ord = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("fx_order", gq[i], exp_ord[i]);

    // fixed instance timeout after MAX_WAIT=3 issue cycles
    @(negedge clk);
    fx_m_ready = 1'b0;
    fx_addr[31:16] = 16'h0300;
    fx_req = 2'b10;
    n = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (fx_ack != 0) done = 1;
      else if (fx_m_req) n++;
    end
    if (!done) chk("fx_to_budget", 0, 1);
    chk("fx_to_len", n, 3);
    chk("fx_to_ack", fx_ack, 2'b10);
    chk("fx_to_err", fx_err, 2'b10);
    chk("fx_to_rdata", fx_rdata, 0);
    fx_req = 2'b00;
    @(negedge clk);
    chk("fx_to_idle", fx_m_req, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
